// File: rtl/biquad8_pkg.sv
// rtl/biquad8_pkg.sv - shared state encoding, table entry layout and update-write constants
package biquad8_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_LATCH,
    ST_WRITE,
    ST_GAP,
    ST_UPDATE,
    ST_DONE,
    ST_ABORT
  } state_t;

  localparam int ENT_VALID   = 31;
  localparam int ENT_TADR_HI = 24;
  // Only the word-address part of the target field reaches the bus.
  localparam int ENT_TADR_LO = 20;
  localparam int ENT_COEF_HI = 17;
  localparam int ENT_COEF_LO = 0;
  localparam int TADR_W      = ENT_TADR_HI - ENT_TADR_LO + 1;
  localparam int COEF_W      = ENT_COEF_HI - ENT_COEF_LO + 1;

  localparam logic [6:0]  UPDATE_ADR = 7'h00;
  localparam logic [31:0] UPDATE_DAT = 32'h1;
  localparam logic [3:0]  UPDATE_SEL = 4'h1;
  localparam logic [3:0]  COEF_SEL   = 4'hF;

  function automatic logic is_bus_state(input state_t s);
    return (s == ST_WRITE) || (s == ST_UPDATE);
  endfunction

endpackage

// File: rtl/wb_timeout_ctr.sv
// rtl/wb_timeout_ctr.sv - bus response watchdog; expires on the cycle whose increment reaches TIMEOUT
module wb_timeout_ctr #(
  parameter int TIMEOUT = 255
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam logic [15:0] LAST_CNT = 16'(TIMEOUT - 1);

  logic [15:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + 16'd1;
    end
  end

  assign o_expired = i_enable && (r_count == LAST_CNT);

endmodule

// File: rtl/biquad8_coeff_loader.sv
// rtl/biquad8_coeff_loader.sv - walks the coefficient table and writes each valid entry over WISHBONE
// followed by a single update-commit write; every output is a register fed from next-state decode.
module biquad8_coeff_loader
  import biquad8_pkg::*;
#(
  parameter int NENTRIES    = 32,
  parameter int TBL_ADRBITS = 5,
  parameter int TIMEOUT     = 255
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic                   start_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o,
  output logic [TBL_ADRBITS-1:0] tbl_adr_o,
  output logic                   tbl_rd_o,
  input  logic [31:0]            tbl_dat_i,
  output logic                   wb_cyc_o,
  output logic                   wb_stb_o,
  output logic                   wb_we_o,
  output logic [6:0]             wb_adr_o,
  output logic [31:0]            wb_dat_o,
  output logic [3:0]             wb_sel_o,
  input  logic                   wb_ack_i,
  input  logic                   wb_err_i,
  input  logic                   wb_rty_i,
  input  logic [31:0]            wb_dat_i
);

  localparam logic [TBL_ADRBITS-1:0] LAST_IDX = TBL_ADRBITS'(NENTRIES - 1);

  state_t                   r_state;
  state_t                   r_gap_tgt;
  logic [TBL_ADRBITS-1:0]   r_index;
  logic [TADR_W-1:0]        r_ent_tadr;
  logic [COEF_W-1:0]        r_ent_coef;
  logic                     r_busy;
  logic                     r_done;
  logic                     r_err;
  logic                     r_tbl_rd;
  logic                     r_cyc;
  logic [6:0]               r_adr;
  logic [31:0]              r_dat;
  logic [3:0]               r_sel;

  state_t                   w_state_nxt;
  state_t                   w_gap_tgt_nxt;
  logic [TBL_ADRBITS-1:0]   w_index_nxt;
  logic [TADR_W-1:0]        w_tadr_src;
  logic [COEF_W-1:0]        w_coef_src;
  logic [6:0]               w_bus_adr;
  logic [31:0]              w_bus_dat;
  logic [3:0]               w_bus_sel;
  logic                     w_resp;
  logic                     w_to_clear;
  logic                     w_to_enable;
  logic                     w_to_expired;
  logic                     w_unused;

  assign w_resp      = wb_ack_i | wb_err_i | wb_rty_i;
  assign w_to_enable = is_bus_state(r_state) && !w_resp;
  assign w_to_clear  = is_bus_state(w_state_nxt) && !is_bus_state(r_state);
  assign w_unused    = ^{wb_dat_i, tbl_dat_i[30:25], tbl_dat_i[19:18]};

  // The entry is still on tbl_dat_i while leaving LATCH; afterwards (retries) it comes from the capture.
  assign w_tadr_src = (r_state == ST_LATCH) ? tbl_dat_i[ENT_TADR_HI:ENT_TADR_LO] : r_ent_tadr;
  assign w_coef_src = (r_state == ST_LATCH) ? tbl_dat_i[ENT_COEF_HI:ENT_COEF_LO] : r_ent_coef;

  wb_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .i_clk     (wb_clk_i),
    .i_rst     (wb_rst_i),
    .i_clear   (w_to_clear),
    .i_enable  (w_to_enable),
    .o_expired (w_to_expired)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_gap_tgt_nxt = r_gap_tgt;
    w_index_nxt   = r_index;
    w_bus_adr     = '0;
    w_bus_dat     = '0;
    w_bus_sel     = '0;

    case (r_state)
      ST_IDLE: begin
        if (start_i) begin
          w_state_nxt = ST_READ;
          w_index_nxt = '0;
        end
      end
      ST_READ:  w_state_nxt = ST_LATCH;
      ST_LATCH: w_state_nxt = tbl_dat_i[ENT_VALID] ? ST_WRITE : ST_UPDATE;
      ST_WRITE: begin
        if (wb_err_i || w_to_expired) begin
          w_state_nxt = ST_ABORT;
        end else if (wb_ack_i) begin
          w_state_nxt   = ST_GAP;
          w_index_nxt   = r_index + 1'b1;
          w_gap_tgt_nxt = (r_index == LAST_IDX) ? ST_UPDATE : ST_READ;
        end else if (wb_rty_i) begin
          w_state_nxt   = ST_GAP;
          w_gap_tgt_nxt = ST_WRITE;
        end
      end
      ST_GAP: w_state_nxt = r_gap_tgt;
      ST_UPDATE: begin
        if (wb_err_i || w_to_expired) begin
          w_state_nxt = ST_ABORT;
        end else if (wb_ack_i) begin
          w_state_nxt = ST_DONE;
        end else if (wb_rty_i) begin
          w_state_nxt   = ST_GAP;
          w_gap_tgt_nxt = ST_UPDATE;
        end
      end
      ST_DONE:  w_state_nxt = ST_IDLE;
      ST_ABORT: w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase

    if (w_state_nxt == ST_WRITE) begin
      w_bus_adr = {w_tadr_src, 2'b00};
      w_bus_dat = {{(32 - COEF_W){1'b0}}, w_coef_src};
      w_bus_sel = COEF_SEL;
    end else if (w_state_nxt == ST_UPDATE) begin
      w_bus_adr = UPDATE_ADR;
      w_bus_dat = UPDATE_DAT;
      w_bus_sel = UPDATE_SEL;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state   <= ST_IDLE;
      r_gap_tgt <= ST_IDLE;
      r_index   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_gap_tgt <= w_gap_tgt_nxt;
      r_index   <= w_index_nxt;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_ent_tadr <= '0;
      r_ent_coef <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_tbl_rd   <= 1'b0;
      r_cyc      <= 1'b0;
      r_adr      <= '0;
      r_dat      <= '0;
      r_sel      <= '0;
    end else begin
      if (r_state == ST_LATCH) begin
        r_ent_tadr <= w_tadr_src;
        r_ent_coef <= w_coef_src;
      end
      r_busy   <= (w_state_nxt != ST_IDLE);
      r_done   <= (w_state_nxt == ST_DONE);
      r_err    <= (w_state_nxt == ST_ABORT);
      r_tbl_rd <= (w_state_nxt == ST_READ);
      r_cyc    <= is_bus_state(w_state_nxt);
      r_adr    <= w_bus_adr;
      r_dat    <= w_bus_dat;
      r_sel    <= w_bus_sel;
    end
  end

  assign busy_o    = r_busy;
  assign done_o    = r_done;
  assign err_o     = r_err;
  assign tbl_rd_o  = r_tbl_rd;
  assign tbl_adr_o = r_index;
  assign wb_cyc_o  = r_cyc;
  assign wb_stb_o  = r_cyc;
  assign wb_we_o   = r_cyc;
  assign wb_adr_o  = r_adr;
  assign wb_dat_o  = r_dat;
  assign wb_sel_o  = r_sel;

endmodule

// File: tb/tb_biquad8_coeff_loader.sv
// tb/tb_biquad8_coeff_loader.sv - scoreboard bench: table model, WISHBONE target model, write checker
module tb_biquad8_coeff_loader;

  localparam int NENT  = 4;
  localparam int TBITS = 3;
  localparam int TOUT  = 10;
  localparam int DLY   = 3;

  localparam int M_ACK      = 0;
  localparam int M_RTY1     = 1;
  localparam int M_NONE     = 2;
  localparam int M_ACKERR   = 3;
  localparam int M_ACK_ONCE = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start_i;
  logic             busy_o, done_o, err_o;
  logic [TBITS-1:0] tbl_adr_o;
  logic             tbl_rd_o;
  logic [31:0]      tbl_dat_i;
  logic             wb_cyc_o, wb_stb_o, wb_we_o;
  logic [6:0]       wb_adr_o;
  logic [31:0]      wb_dat_o;
  logic [3:0]       wb_sel_o;
  logic             wb_ack_i, wb_err_i, wb_rty_i;
  logic [31:0]      wb_dat_i;

  biquad8_coeff_loader #(
    .NENTRIES    (NENT),
    .TBL_ADRBITS (TBITS),
    .TIMEOUT     (TOUT)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .start_i   (start_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .err_o     (err_o),
    .tbl_adr_o (tbl_adr_o),
    .tbl_rd_o  (tbl_rd_o),
    .tbl_dat_i (tbl_dat_i),
    .wb_cyc_o  (wb_cyc_o),
    .wb_stb_o  (wb_stb_o),
    .wb_we_o   (wb_we_o),
    .wb_adr_o  (wb_adr_o),
    .wb_dat_o  (wb_dat_o),
    .wb_sel_o  (wb_sel_o),
    .wb_ack_i  (wb_ack_i),
    .wb_err_i  (wb_err_i),
    .wb_rty_i  (wb_rty_i),
    .wb_dat_i  (wb_dat_i)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  localparam logic [44:0] EXP_UPD = {1'b1, 1'b1, 4'h1, 7'h00, 32'h1};

  logic [4:0]  ta  [NENT] = '{5'd1, 5'd2, 5'd3, 5'd4};
  logic [1:0]  tlo [NENT] = '{2'd3, 2'd1, 2'd2, 2'd0};
  logic [17:0] tco [NENT] = '{18'h3FFFF, 18'h00001, 18'h2A5A5, 18'h12345};

  logic [31:0] tbl_mem [8];
  logic [44:0] sb[$];

  int   mode;
  int   acks_left;
  logic rty_pending;
  int   done_cnt, err_cnt, nwrites, unstable;
  int   wait_cnt, low_cnt, last_len, gap_rty;
  logic in_cyc, chk_drop, gap_watch, rd_d;
  logic [44:0] cur, exp_w;

  function automatic logic [31:0] mk(input logic v, input logic [4:0] a, input logic [1:0] lo,
                                     input logic [17:0] c);
    return {v, 6'b101101, a, lo, c};
  endfunction

  function automatic logic [44:0] exp_coef(input logic [4:0] a, input logic [17:0] c);
    return {1'b1, 1'b1, 4'hF, a, 2'b00, 14'b0, c};
  endfunction

  task automatic load_table(input int invalid_idx);
    for (int i = 0; i < 8; i++) tbl_mem[i] = 32'h5A5A_5A5A;
    for (int i = 0; i < NENT; i++) tbl_mem[i] = mk(i != invalid_idx, ta[i], tlo[i], tco[i]);
  endtask

  task automatic push_entries(input int n, input logic with_upd);
    for (int i = 0; i < n; i++) sb.push_back(exp_coef(ta[i], tco[i]));
    if (with_upd) sb.push_back(EXP_UPD);
  endtask

  task automatic clear_counts(input int m);
    mode = m; acks_left = 1; rty_pending = 1'b1;
    done_cnt = 0; err_cnt = 0; nwrites = 0; unstable = 0;
    last_len = 0; gap_rty = -1;
    sb.delete();
  endtask

  task automatic run_seq(input string nm, input int budget);
    int n;
    @(negedge clk); start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    n = 0;
    while (busy_o && n < budget) begin @(negedge clk); n++; end
    check({nm, "_finish"}, 64'(n < budget), 64'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic end_checks(input string nm, input int wr, input int dn, input int er);
    check({nm, "_sb_left"}, 64'(sb.size()), 64'd0);
    check({nm, "_writes"}, 64'(nwrites), 64'(wr));
    check({nm, "_done"}, 64'(done_cnt), 64'(dn));
    check({nm, "_err"}, 64'(err_cnt), 64'(er));
    check({nm, "_stable"}, 64'(unstable), 64'd0);
    check({nm, "_idle"}, 64'(busy_o), 64'd0);
  endtask

  // Table memory and WISHBONE target, evaluated mid-cycle so nothing races the active edge.
  initial begin
    in_cyc = 1'b0; chk_drop = 1'b0; gap_watch = 1'b0; rd_d = 1'b0;
    wait_cnt = 0; low_cnt = 0;
    forever begin
      @(negedge clk);
      if (tbl_rd_o) tbl_dat_i = tbl_mem[tbl_adr_o];
      else if (!rd_d) tbl_dat_i = 32'h5A5A_5A5A;
      rd_d = tbl_rd_o;
      done_cnt += int'(done_o);
      err_cnt  += int'(err_o);
      if (chk_drop) begin
        check("cyc_drop", 64'({wb_cyc_o, wb_stb_o}), 64'd0);
        chk_drop = 1'b0;
      end
      wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
      if (wb_cyc_o) begin
        if (!in_cyc) begin
          in_cyc = 1'b1; wait_cnt = 0;
          if (gap_watch) begin gap_rty = low_cnt; gap_watch = 1'b0; end
          cur = {wb_we_o, wb_stb_o, wb_sel_o, wb_adr_o, wb_dat_o};
          exp_w = (sb.size() > 0) ? sb.pop_front() : 45'h0;
          check("bus_write", 64'(cur), 64'(exp_w));
          nwrites++;
        end else if ({wb_we_o, wb_stb_o, wb_sel_o, wb_adr_o, wb_dat_o} != cur) begin
          unstable++;
        end
        wait_cnt++;
        if (wait_cnt == DLY) begin
          case (mode)
            M_ACK: wb_ack_i = 1'b1;
            M_RTY1: begin
              if (rty_pending) begin wb_rty_i = 1'b1; rty_pending = 1'b0; gap_watch = 1'b1; end
              else wb_ack_i = 1'b1;
            end
            M_ACKERR: begin wb_ack_i = 1'b1; wb_err_i = 1'b1; end
            M_ACK_ONCE: if (acks_left > 0) begin wb_ack_i = 1'b1; acks_left--; end
            default: ;
          endcase
          chk_drop = wb_ack_i | wb_err_i | wb_rty_i;
        end
      end else begin
        if (in_cyc) begin in_cyc = 1'b0; last_len = wait_cnt; low_cnt = 0; end
        low_cnt++;
      end
    end
  end

  initial begin
    int n;
    rst = 1'b1; start_i = 1'b0; tbl_dat_i = '0; wb_dat_i = 32'hFFFF_FFFF;
    wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
    clear_counts(M_ACK);
    load_table(-1);
    repeat (3) @(negedge clk);
    check("reset_outputs",
          64'({busy_o, done_o, err_o, tbl_rd_o, tbl_adr_o, wb_cyc_o, wb_stb_o, wb_we_o,
               wb_adr_o, wb_sel_o}), 64'd0);
    check("reset_dat", 64'(wb_dat_o), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Full table, all entries acknowledged
    clear_counts(M_ACK);
    load_table(-1);
    push_entries(NENT, 1'b1);
    run_seq("full", 200);
    end_checks("full", NENT + 1, 1, 0);

    // Early table end at entry 2
    clear_counts(M_ACK);
    load_table(2);
    push_entries(2, 1'b1);
    run_seq("early", 200);
    end_checks("early", 3, 1, 0);

    // Retry on the first write: same write after a single idle cycle
    clear_counts(M_RTY1);
    load_table(-1);
    sb.push_back(exp_coef(ta[0], tco[0]));
    push_entries(NENT, 1'b1);
    run_seq("retry", 200);
    check("retry_gap", 64'(gap_rty), 64'd1);
    end_checks("retry", NENT + 2, 1, 0);

    // Silent target: watchdog abort, no update write
    clear_counts(M_NONE);
    load_table(-1);
    push_entries(1, 1'b0);
    run_seq("tmo", 200);
    check("tmo_cyc_len", 64'(last_len), 64'(TOUT));
    end_checks("tmo", 1, 0, 1);

    // Asynchronous reset during the second write, then a clean reload from entry 0
    clear_counts(M_ACK_ONCE);
    load_table(-1);
    push_entries(2, 1'b0);
    @(negedge clk); start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    n = 0;
    while (nwrites < 2 && n < 200) begin @(negedge clk); n++; end
    check("rst_reach_wr2", 64'(nwrites), 64'd2);
    #2 rst = 1'b1;
    #1;
    check("rst_async_bus", 64'({wb_cyc_o, wb_stb_o, wb_we_o, busy_o, wb_sel_o}), 64'd0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    check("rst_no_pulse", 64'({done_cnt[15:0], err_cnt[15:0]}), 64'd0);
    mode = M_ACK;
    push_entries(NENT, 1'b1);
    run_seq("reload", 200);
    end_checks("reload", NENT + 3, 1, 0);

    // Start pulse while busy, then ack and err together
    clear_counts(M_ACKERR);
    load_table(-1);
    push_entries(1, 1'b0);
    @(negedge clk); start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    n = 0;
    while (!wb_cyc_o && n < 50) begin @(negedge clk); n++; end
    check("ackerr_reach_wr", 64'(wb_cyc_o), 64'd1);
    start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    n = 0;
    while (busy_o && n < 200) begin @(negedge clk); n++; end
    repeat (6) @(negedge clk);
    end_checks("ackerr", 1, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/biquad8_coeff_loader.md
BIQUAD8_COEFF_LOADER -- requirements
Module: biquad8_coeff_loader

Interface
REQ-001 SHALL have parameter NENTRIES, default 32: number of coefficient table entries (2..256).
REQ-002 SHALL have parameter TBL_ADRBITS, default 5: table address width; NENTRIES SHALL be at most 2**TBL_ADRBITS.
REQ-003 SHALL have parameter TIMEOUT, default 255: cycles to wait for a terminating response before aborting (1..65535).
REQ-004 SHALL have ports: wb_clk_i  in  1  single clock (one clock; reset is asynchronous and active-high).
REQ-005 wb_rst_i  in  1  asynchronous active-high reset.
REQ-006 start_i  in  1  one-cycle pulse; begins a load sequence.
REQ-007 busy_o  out  1  high while a sequence is in progress.
REQ-008 done_o  out  1  one-cycle pulse; sequence completed, update written.
REQ-009 err_o  out  1  one-cycle pulse; sequence aborted.
REQ-010 tbl_adr_o  out  TBL_ADRBITS  table read address.
REQ-011 tbl_rd_o  out  1  table read strobe; tbl_dat_i valid the following cycle.
REQ-012 tbl_dat_i  in  32  entry: [31] valid, [30:25] reserved, [24:18] target address, [17:0] coefficient.
REQ-013 wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  WISHBONE initiator controls.
REQ-014 wb_adr_o  out  7  target byte address; wb_dat_o  out  32; wb_sel_o  out  4.
REQ-015 wb_ack_i, wb_err_i, wb_rty_i  in  1 each; wb_dat_i  in  32 (ignored).

Function
REQ-016 States: IDLE, READ, LATCH, WRITE, GAP, UPDATE, DONE, ABORT.
REQ-017 IDLE: on start_i, index=0, go READ; start_i outside IDLE SHALL be ignored.
REQ-018 READ: tbl_rd_o=1, tbl_adr_o=index for one cycle; go LATCH.
REQ-019 LATCH: capture tbl_dat_i; if valid=0 go UPDATE (early table end), else go WRITE.
REQ-020 WRITE: cyc=stb=we=1, adr={entry[24:20],2'b00}, dat={14'b0,entry[17:0]}, sel=4'hF, held stable until a response.
REQ-021 A response (ack, err or rty) SHALL be sampled on a clock edge; cyc and stb SHALL be low the following cycle.
REQ-022 On ack in WRITE: go GAP; index increments; if index was NENTRIES-1 the GAP SHALL exit to UPDATE, else to READ.
REQ-023 On rty: go GAP, then re-issue the same write with index unchanged.
REQ-024 GAP SHALL hold cyc and stb low for exactly one cycle.
REQ-025 UPDATE: write adr=7'h00, dat=32'h1, sel=4'h1; on ack go DONE; rty behaves as in WRITE.
REQ-026 DONE: done_o=1 for one cycle; go IDLE.
REQ-027 err_i, or the timeout counter reaching TIMEOUT, in WRITE or UPDATE SHALL go to ABORT; cyc and stb are low in ABORT.
REQ-028 ABORT: err_o=1 for one cycle; go IDLE; no update write issued.
REQ-029 Timeout counter SHALL clear on entry to WRITE and UPDATE, and increment each cycle without a response.
REQ-030 If ack and err are high together, err SHALL take priority; err priority over rty likewise.
REQ-031 busy_o SHALL be high in every state except IDLE.
REQ-032 All outputs SHALL be registered; ack_i SHALL NOT combinationally affect any output.
REQ-033 An all-valid table SHALL produce exactly NENTRIES coefficient writes plus one update write.

Reset
REQ-034 wb_rst_i asserted, including mid-transaction: state=IDLE, index=0, timeout=0, all outputs 0, immediately (asynchronous).
REQ-035 No done_o or err_o pulse SHALL be produced as a result of reset.

Structure
REQ-036 State enum, entry bit-field positions, UPDATE_ADR=7'h00 and UPDATE_DAT=32'h1 SHALL live in shared package biquad8_pkg.
REQ-037 The timeout counter SHALL be a separate sub-module, wb_timeout_ctr (clear, enable, expired).

Verification
REQ-038 NENTRIES=4, all valid, target ack after 3 cycles -> writes to 0x04,0x08,0x0C,0x10 with data as in the table, then 0x00/0x1/sel 1; done_o once; 5 acks total.
REQ-039 Entry 2 valid=0 -> writes for entries 0,1 only, then update; done_o pulse.
REQ-040 rty on the first write -> one-cycle gap, same adr/dat re-issued; sequence completes normally.
REQ-041 TIMEOUT=10, target never responds -> cyc drops on cycle 11 of WRITE; err_o pulse; no update write.
REQ-042 wb_rst_i during WRITE -> cyc/stb low immediately; busy_o=0; a following start_i reloads from index 0.
REQ-043 start_i pulsed while busy, and ack together with err -> start ignored; abort taken (err_o), no done_o.
